pkt_channel_buffer: RTL
=======================

# pkt_channel_buffer

Store-and-forward packet buffer for one arbiter input channel. It is the generalised successor of the single-packet channel buffer. It accepts a sop/eop framed stream and holds up to 2^PKT_ADDR_WIDTH complete packets in a shared data RAM. Malformed, errored or oversize packets are discarded by pointer rollback, and committed packets are released whole, one per arbiter grant. It sits between a channel ingress and the arbiter's `ctrl_*` grant interface.

## Interface
- DATA_WIDTH, 128, data word width.
- BYTES_WIDTH, 4, width of `i_bytes`/`o_bytes` (valid bytes in the word).
- ADDR_WIDTH, 9, data RAM depth is 2^ADDR_WIDTH words.
- PKT_ADDR_WIDTH, 4, descriptor FIFO depth is 2^PKT_ADDR_WIDTH packets.
- MIN_LEN, 1, minimum packet length in words.
- MAX_LEN, 100, maximum packet length in words; must satisfy MAX_LEN ≤ 2^ADDR_WIDTH.
- SEOP_CHECK, "ON", enforce sop/eop framing.
- ERROR_CHECK, "ON", drop packets whose eop word carries `i_error`.
- RAM_TYPE, "BRAM", data RAM style ("BRAM"/"LUTRAM"); read latency is 1 cycle either way.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- o_busy  out  1  registered; high when free words < MAX_LEN or descriptor FIFO full.
- i_sop, i_eop, i_valid  in  1 each  ingress framing/qualifier.
- i_data  in  DATA_WIDTH  ingress word.
- i_bytes  in  BYTES_WIDTH  valid bytes.
- i_error  in  1  error flag.
- o_sop, o_eop, o_valid  out  1 each  egress framing/qualifier.
- o_data  out  DATA_WIDTH  egress word.
- o_bytes  out  BYTES_WIDTH  egress valid bytes.
- o_error  out  1  egress error flag.
- ctrl_ready  out  1  a committed packet can be granted this cycle.
- ctrl_eop  out  1  one-cycle pulse when the final RAM read of the current packet is issued.
- ctrl_sel  in  1  grant, sampled only while `ctrl_ready`=1.
- o_drop_cnt  out  16  dropped-packet counter (see Configuration).

## Operation
- **Write FSM**: IDLE, RECV, DROP.
- **IDLE**:
  - `i_valid&i_sop` stores the word at wr_ptr, sets len=1, then goes to RECV. If `i_eop` is also set, the eop rules apply immediately.
  - `i_valid` without sop is discarded when SEOP_CHECK="ON" (counts as a drop). With SEOP_CHECK="OFF" it is treated as sop.
- **RECV**:
  - Each valid word is written and increments len.
  - `i_sop` while SEOP_CHECK="ON" rolls back the current packet (drop) and restarts with this word.
  - The word that would make len > MAX_LEN, or a write into a full RAM, rolls back and moves to DROP.
- **DROP**: discards words until `i_eop`, then goes to IDLE. One drop is counted per packet.
- **At eop**: rollback (wr_ptr ← commit_ptr, drop) if len < MIN_LEN, or if `i_error`=1 with ERROR_CHECK="ON". Otherwise commit: push descriptor {len}, commit_ptr ← wr_ptr+1.
- **RAM word format**: {error, bytes, data}. With ERROR_CHECK="OFF", errors are stored and forwarded.
- **Pointer widths**: all pointers are ADDR_WIDTH+1 bits; addresses wrap modulo 2^ADDR_WIDTH.
  - used = commit_ptr−rd_ptr + uncommitted words.
  - free = 2^ADDR_WIDTH − (wr_ptr−rd_ptr).
- **Read FSM**: IDLE, READ.
  - `ctrl_ready` = descriptor FIFO non-empty and (IDLE, or READ on the last read).
  - `ctrl_sel` pops a descriptor and issues len consecutive RAM reads, one per cycle. There is no backpressure.
  - The RAM space of a word is freed when that word is read.

## Timing
- **Reset**: every output is 0, including `o_busy`, `ctrl_ready` and `o_drop_cnt`. All pointers and FSMs clear; buffered packets are lost. Reset mid-packet truncates nothing downstream beyond dropping `o_valid` at once.
- **Commit to grant**: eop written in cycle E; `ctrl_ready` may be high from E+1.
- **Grant to output**: `ctrl_sel` in cycle T gives `o_valid&o_sop` at T+2, `o_eop` at T+1+len, and `ctrl_eop` at T+len.
- **Back-to-back grants**: `ctrl_sel` in the `ctrl_eop` cycle puts the next `o_sop` in the cycle after `o_eop`, with no gap.
- **Single-word packet**: `o_sop`=`o_eop` in the same cycle.
- **Simultaneous events**: a same-cycle descriptor push and pop leaves the count unchanged. A same-cycle write and read of the same address is impossible, because only committed words are read.
- **o_busy**: updated one cycle after the pointer change. Upstream must not start a packet while `o_busy`=1; if it does, the overflow is dropped.

## Configuration
- `PKT_CHANNEL_BUFFER_STATS_EN` defined: `o_drop_cnt` increments once per dropped packet or discarded orphan word, and saturates at 16'hFFFF.
- Undefined: `o_drop_cnt` is tied to 0 and the counter logic is absent. The port is retained.

## Test plan
- 3-word packet (len 3, i_bytes 5 on eop) → `ctrl_ready` at E+1; `ctrl_sel` at T → `o_sop` at T+2, `o_eop`/`o_bytes`=5 at T+4, `ctrl_eop` at T+3.
- Two committed packets (2 and 1 words), `ctrl_sel` held high at each `ctrl_ready` → 3 contiguous `o_valid` cycles, `o_sop` on words 1 and 3.
- 101-word packet with MAX_LEN=100 → nothing committed, `ctrl_ready` stays 0, `o_drop_cnt`=1 (macro defined), free space restored.
- ERROR_CHECK="ON", eop with `i_error`=1 → packet dropped. ERROR_CHECK="OFF" → forwarded with `o_error`=1 on `o_eop`.
- SEOP_CHECK="ON": sop, data, sop, eop → only the second packet (2 words) is output; drop count 1.
- Fill to 16 packets with PKT_ADDR_WIDTH=4 → `o_busy`=1. One grant → `o_busy`=0 one cycle after the pop. Assert reset mid-read → all outputs 0 immediately.

Source files
------------

// File: rtl/pkt_channel_buffer.sv
// Store-and-forward packet buffer for one arbiter input channel; drops bad packets by pointer rollback.
// Optional drop statistics are enabled by defining PKT_CHANNEL_BUFFER_STATS_EN.
module pkt_channel_buffer #(
  parameter int    DATA_WIDTH     = 128,
  parameter int    BYTES_WIDTH    = 4,
  parameter int    ADDR_WIDTH     = 9,
  parameter int    PKT_ADDR_WIDTH = 4,
  parameter int    MIN_LEN        = 1,
  parameter int    MAX_LEN        = 100,
  parameter string SEOP_CHECK     = "ON",
  parameter string ERROR_CHECK    = "ON",
  parameter string RAM_TYPE       = "BRAM"
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   o_busy,
  input  logic                   i_sop,
  input  logic                   i_eop,
  input  logic                   i_valid,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic [BYTES_WIDTH-1:0] i_bytes,
  input  logic                   i_error,
  output logic                   o_sop,
  output logic                   o_eop,
  output logic                   o_valid,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic [BYTES_WIDTH-1:0] o_bytes,
  output logic                   o_error,
  output logic                   ctrl_ready,
  output logic                   ctrl_eop,
  input  logic                   ctrl_sel,
  output logic [15:0]            o_drop_cnt
);
  localparam int LW = ADDR_WIDTH + 1;
  localparam int PW = PKT_ADDR_WIDTH + 1;
  localparam int RW = 1 + BYTES_WIDTH + DATA_WIDTH;
  localparam logic [LW-1:0] RAM_WORDS  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PW-1:0] DESC_WORDS = {1'b1, {PKT_ADDR_WIDTH{1'b0}}};
  localparam logic [LW-1:0] MAX_L = LW'(MAX_LEN);
  localparam logic [LW-1:0] MIN_L = LW'(MIN_LEN);
  localparam logic [LW-1:0] ONE_L = LW'(1);
  localparam logic [PW-1:0] ONE_P = PW'(1);
  localparam bit SEOP_ON = (SEOP_CHECK == "ON");
  localparam bit ERR_ON  = (ERROR_CHECK == "ON");

  typedef enum logic [1:0] {W_IDLE, W_RECV, W_DROP} wstate_t;
  typedef enum logic {R_IDLE, R_READ} rstate_t;

  wstate_t wstate, wstate_nxt;
  rstate_t rstate, rstate_nxt;
  logic [LW-1:0] wr_ptr, wr_ptr_nxt, commit_ptr, commit_ptr_nxt, len, len_nxt;
  logic [LW-1:0] rd_ptr, rd_ptr_nxt, rd_cnt, rd_cnt_nxt;
  logic [LW-1:0] base_ptr, base_len, pkt_len, free;
  logic [PW-1:0] desc_cnt;
  logic [PKT_ADDR_WIDTH-1:0] desc_wr, desc_rd;
  logic [LW-1:0] desc_mem [2**PKT_ADDR_WIDTH];
  logic [RW-1:0] ram_q;
  logic [1:0] drop_inc;
  logic accept, restart, drop_now, ovf, bad, ram_we, push, pop, desc_full;
  logic rd_en, rd_last, rd_first, rd_first_nxt;

  // Uncommitted words count against free space so a growing packet cannot overrun unread data.
  assign free      = RAM_WORDS - (wr_ptr - rd_ptr);
  assign desc_full = (desc_cnt == DESC_WORDS);

  always_comb begin
    wstate_nxt     = wstate;
    wr_ptr_nxt     = wr_ptr;
    commit_ptr_nxt = commit_ptr;
    len_nxt        = len;
    ram_we         = 1'b0;
    push           = 1'b0;
    accept         = 1'b0;
    drop_now       = 1'b0;
    restart        = i_valid && (wstate == W_RECV) && i_sop && SEOP_ON;
    if (i_valid) begin
      case (wstate)
        W_IDLE:  if (i_sop || !SEOP_ON) accept = 1'b1;
                 else drop_now = 1'b1;
        W_RECV:  accept = 1'b1;
        default: if (i_eop) wstate_nxt = W_IDLE;
      endcase
    end
    // A restart reuses the rolled-back region, so it builds on commit_ptr like a fresh packet.
    base_ptr = (wstate == W_RECV && !restart) ? wr_ptr : commit_ptr;
    base_len = (wstate == W_RECV && !restart) ? len : '0;
    pkt_len  = base_len + ONE_L;
    ovf      = (pkt_len > MAX_L) || ((base_ptr - rd_ptr) == RAM_WORDS);
    bad      = (pkt_len < MIN_L) || (i_error && ERR_ON) || desc_full;
    if (accept) begin
      if (ovf) begin
        wr_ptr_nxt = commit_ptr;
        drop_now   = 1'b1;
        wstate_nxt = i_eop ? W_IDLE : W_DROP;
      end else begin
        ram_we = 1'b1;
        if (!i_eop) begin
          wr_ptr_nxt = base_ptr + ONE_L;
          len_nxt    = pkt_len;
          wstate_nxt = W_RECV;
        end else if (bad) begin
          wr_ptr_nxt = commit_ptr;
          drop_now   = 1'b1;
          wstate_nxt = W_IDLE;
        end else begin
          wr_ptr_nxt     = base_ptr + ONE_L;
          commit_ptr_nxt = base_ptr + ONE_L;
          push           = 1'b1;
          wstate_nxt     = W_IDLE;
        end
      end
    end
    drop_inc = {1'b0, restart} + {1'b0, drop_now};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wstate     <= W_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      len        <= '0;
    end else begin
      wstate     <= wstate_nxt;
      wr_ptr     <= wr_ptr_nxt;
      commit_ptr <= commit_ptr_nxt;
      len        <= len_nxt;
    end
  end

  always_comb begin
    rstate_nxt   = rstate;
    rd_ptr_nxt   = rd_ptr;
    rd_cnt_nxt   = rd_cnt;
    rd_first_nxt = rd_first;
    rd_en        = (rstate == R_READ);
    rd_last      = rd_en && (rd_cnt == ONE_L);
    ctrl_ready   = (desc_cnt != '0) && ((rstate == R_IDLE) || rd_last);
    ctrl_eop     = rd_last;
    pop          = ctrl_ready && ctrl_sel;
    if (rd_en) begin
      rd_ptr_nxt   = rd_ptr + ONE_L;
      rd_cnt_nxt   = rd_cnt - ONE_L;
      rd_first_nxt = 1'b0;
      if (rd_last) rstate_nxt = R_IDLE;
    end
    // A grant on the last read chains the next packet with no idle cycle.
    if (pop) begin
      rstate_nxt   = R_READ;
      rd_cnt_nxt   = desc_mem[desc_rd];
      rd_first_nxt = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rstate   <= R_IDLE;
      rd_ptr   <= '0;
      rd_cnt   <= '0;
      rd_first <= 1'b0;
      desc_cnt <= '0;
      desc_wr  <= '0;
      desc_rd  <= '0;
      o_valid  <= 1'b0;
      o_sop    <= 1'b0;
      o_eop    <= 1'b0;
      o_busy   <= 1'b0;
    end else begin
      rstate   <= rstate_nxt;
      rd_ptr   <= rd_ptr_nxt;
      rd_cnt   <= rd_cnt_nxt;
      rd_first <= rd_first_nxt;
      if (push) desc_wr <= desc_wr + 1'b1;
      if (pop)  desc_rd <= desc_rd + 1'b1;
      if (push && !pop)      desc_cnt <= desc_cnt + ONE_P;
      else if (pop && !push) desc_cnt <= desc_cnt - ONE_P;
      o_valid  <= rd_en;
      o_sop    <= rd_en && rd_first;
      o_eop    <= rd_last;
      o_busy   <= (free < MAX_L) || desc_full;
    end
  end

  always_ff @(posedge clock) begin
    if (push) desc_mem[desc_wr] <= pkt_len;
  end

  if (RAM_TYPE == "LUTRAM") begin : g_lutram
    (* ram_style = "distributed" *) logic [RW-1:0] mem [2**ADDR_WIDTH];
    always_ff @(posedge clock) begin
      if (ram_we) mem[base_ptr[ADDR_WIDTH-1:0]] <= {i_error, i_bytes, i_data};
    end
    always_ff @(posedge clock or posedge reset) begin
      if (reset)      ram_q <= '0;
      else if (rd_en) ram_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
    end
  end else begin : g_bram
    (* ram_style = "block" *) logic [RW-1:0] mem [2**ADDR_WIDTH];
    always_ff @(posedge clock) begin
      if (ram_we) mem[base_ptr[ADDR_WIDTH-1:0]] <= {i_error, i_bytes, i_data};
    end
    always_ff @(posedge clock or posedge reset) begin
      if (reset)      ram_q <= '0;
      else if (rd_en) ram_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
    end
  end

  assign {o_error, o_bytes, o_data} = ram_q;

`ifdef PKT_CHANNEL_BUFFER_STATS_EN
  logic [15:0] drop_cnt;
  logic [16:0] drop_sum;
  assign drop_sum = {1'b0, drop_cnt} + {15'd0, drop_inc};
  always_ff @(posedge clock or posedge reset) begin
    if (reset) drop_cnt <= '0;
    else       drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end
  assign o_drop_cnt = drop_cnt;
`else
  logic unused_drop;
  assign unused_drop = ^drop_inc;
  assign o_drop_cnt  = '0;
`endif
endmodule
